// File: rtl/pipeline_exit_monitor_if.sv
// Run-control bundle between the testbench/host side and the exit monitor.
// The master drives start/exit_addr and mirrors the core's pc/stall; the slave reports status.
interface pipeline_exit_monitor_if #(
    parameter int unsigned CNT_W = 16
);
    logic             start;
    logic [31:0]      exit_addr;
    logic [31:0]      pc;
    logic             stall;
    logic             busy;
    logic             done;
    logic [1:0]       status;
    logic [CNT_W-1:0] cycles;

    modport master (
        output start, exit_addr, pc, stall,
        input  busy, done, status, cycles
    );

    modport slave (
        input  start, exit_addr, pc, stall,
        output busy, done, status, cycles
    );
endinterface

// File: rtl/pipeline_exit_monitor.sv
// Watches the fetch PC for the exit address, drains the pipeline, reports pass/timeout/error.
// Optional PC_RANGE_CHECK_EN: a misaligned or out-of-text PC while running ends the run in ERR.
module pipeline_exit_monitor #(
    parameter logic [31:0] TEXT_START   = 32'h0040_0000,
    parameter int unsigned TEXT_BYTES   = 1024,
    parameter int unsigned DRAIN_CYCLES = 4,
    parameter int unsigned TIMEOUT      = 100,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                    clk,
    input  logic                    rstn,
    pipeline_exit_monitor_if.slave  mon
);

    typedef enum logic [2:0] {
        S_IDLE, S_RUN, S_DRAIN, S_DONE, S_TLE, S_ERR
    } state_t;

    localparam int unsigned DW =
        (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam logic [CNT_W-1:0] TMO      = CNT_W'(TIMEOUT);
    localparam logic [DW-1:0]    DRN      = DW'(DRAIN_CYCLES);
    localparam logic [32:0]      TEXT_END = {1'b0, TEXT_START} + 33'(TEXT_BYTES);
`ifdef PC_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cyc_q, cyc_d, cyc_inc;
    logic [1:0]       st_q, st_d;
    logic [31:0]      exit_q, exit_d;
    logic [DW-1:0]    drn_q, drn_d;
    logic             hit, tmo, pc_bad;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            cyc_q   <= '0;
            st_q    <= 2'b00;
            exit_q  <= '0;
            drn_q   <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            st_q    <= st_d;
            exit_q  <= exit_d;
            drn_q   <= drn_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        st_d    = st_q;
        exit_d  = exit_q;
        drn_d   = drn_q;
        cyc_inc = cyc_q + CNT_W'(1);
        hit     = (mon.pc == exit_q);
        tmo     = (cyc_inc == TMO);
        pc_bad  = RANGE_EN && ((mon.pc < TEXT_START)
                  || ({1'b0, mon.pc} >= TEXT_END)
                  || (mon.pc[1:0] != 2'b00));

        unique case (state_q)
            S_IDLE, S_DONE, S_TLE, S_ERR: begin
                if (mon.start) begin
                    exit_d = mon.exit_addr;
                    cyc_d  = '0;
                    st_d   = 2'b00;
                    // An exit at the first instruction means there is no program.
                    if (mon.exit_addr == TEXT_START) begin
                        state_d = S_ERR;
                        st_d    = 2'b11;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                cyc_d = cyc_inc;
                if (pc_bad) begin
                    state_d = S_ERR;
                    st_d    = 2'b11;
                end else if (hit && DRAIN_CYCLES == 0) begin
                    state_d = S_DONE;
                    st_d    = 2'b01;
                end else if (tmo) begin
                    state_d = S_TLE;
                    st_d    = 2'b10;
                    cyc_d   = TMO;
                end else if (hit) begin
                    state_d = S_DRAIN;
                    drn_d   = DRN;
                end
            end
            S_DRAIN: begin
                cyc_d = cyc_inc;
                if (!mon.stall) drn_d = drn_q - DW'(1);
                // Drain completion beats a coincident timeout.
                if (pc_bad) begin
                    state_d = S_ERR;
                    st_d    = 2'b11;
                end else if (!mon.stall && drn_q == DW'(1)) begin
                    state_d = S_DONE;
                    st_d    = 2'b01;
                end else if (tmo) begin
                    state_d = S_TLE;
                    st_d    = 2'b10;
                    cyc_d   = TMO;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign mon.busy   = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign mon.done   = (state_q == S_DONE) || (state_q == S_TLE)
                        || (state_q == S_ERR);
    assign mon.status = st_q;
    assign mon.cycles = cyc_q;

endmodule

// File: tb/tb_pipeline_exit_monitor.sv
// Directed bench for pipeline_exit_monitor: normal exit, stalled drain,
// timeout, empty program, async reset, busy-start ignore, PC range check.
module tb_pipeline_exit_monitor;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    pipeline_exit_monitor_if #(.CNT_W(16)) mon ();

    pipeline_exit_monitor #(
        .TEXT_START   (32'h0040_0000),
        .TEXT_BYTES   (1024),
        .DRAIN_CYCLES (4),
        .TIMEOUT      (100),
        .CNT_W        (16)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .mon  (mon)
    );

    // {busy, done, status, cycles}
    wire [19:0] obs = {mon.busy, mon.done, mon.status, mon.cycles};
    logic [19:0] exp;
    int pass_cnt = 0;
    int total = 0;

    function automatic logic [19:0] mk(input logic b, input logic d,
                                       input logic [1:0] s, input int c);
        return {b, d, s, 16'(c)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        mon.start = 1'b0;
        mon.stall = 1'b0;
        mon.pc = 32'h0040_0000;
        mon.exit_addr = 32'h0;
        @(negedge clk) rstn = 1'b0;
        @(negedge clk) rstn = 1'b1;
    endtask

    task automatic do_start(input logic [31:0] addr);
        mon.exit_addr = addr;
        mon.start = 1'b1;
        tick();
        mon.start = 1'b0;
    endtask

    task automatic test_reset();
        mon.start = 1'b0;
        mon.stall = 1'b0;
        mon.pc = 32'h0040_0000;
        mon.exit_addr = 32'h0;
        rstn = 1'b0;
        #2;
        exp = mk(0, 0, 2'b00, 0); total++;
        if (obs !== exp) $display("FAIL reset_async got %h exp %h", obs, exp);
        else pass_cnt++;
        mon.start = 1'b1;
        mon.exit_addr = 32'h0040_0014;
        tick(); tick();
        mon.start = 1'b0;
        total++;
        if (obs !== exp) $display("FAIL reset_hold got %h exp %h", obs, exp);
        else pass_cnt++;
        @(negedge clk) rstn = 1'b1;
    endtask

    task automatic test_normal_exit();
        do_reset();
        mon.pc = 32'h0040_0000;
        do_start(32'h0040_0014);
        exp = mk(1, 0, 2'b00, 0); total++;
        if (obs !== exp) $display("FAIL t1_start got %h exp %h", obs, exp);
        else pass_cnt++;
        for (int i = 0; i < 6; i++) begin
            mon.pc = 32'h0040_0000 + 32'(4 * i);
            tick();
        end
        exp = mk(1, 0, 2'b00, 6); total++;
        if (obs !== exp) $display("FAIL t1_detect got %h exp %h", obs, exp);
        else pass_cnt++;
        for (int i = 6; i < 9; i++) begin
            mon.pc = 32'h0040_0000 + 32'(4 * i);
            tick();
        end
        exp = mk(1, 0, 2'b00, 9); total++;
        if (obs !== exp) $display("FAIL t1_drain got %h exp %h", obs, exp);
        else pass_cnt++;
        mon.pc = 32'h0040_0024;
        tick();
        exp = mk(0, 1, 2'b01, 10); total++;
        if (obs !== exp) $display("FAIL t1_done got %h exp %h", obs, exp);
        else pass_cnt++;
        tick(); tick(); tick();
        total++;
        if (obs !== exp) $display("FAIL t1_frozen got %h exp %h", obs, exp);
        else pass_cnt++;
    endtask

    task automatic test_stalled_drain();
        do_reset();
        do_start(32'h0040_0014);
        for (int i = 0; i < 6; i++) begin
            mon.pc = 32'h0040_0000 + 32'(4 * i);
            tick();
        end
        mon.pc = 32'h0040_0018;
        tick();
        mon.stall = 1'b1;
        tick(); tick();
        mon.stall = 1'b0;
        tick(); tick();
        exp = mk(1, 0, 2'b00, 11); total++;
        if (obs !== exp) $display("FAIL t2_pending got %h exp %h", obs, exp);
        else pass_cnt++;
        tick();
        exp = mk(0, 1, 2'b01, 12); total++;
        if (obs !== exp) $display("FAIL t2_done got %h exp %h", obs, exp);
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        do_reset();
        mon.pc = 32'h0040_0008;
        do_start(32'h0040_0020);
        for (int i = 0; i < 99; i++) tick();
        exp = mk(1, 0, 2'b00, 99); total++;
        if (obs !== exp) $display("FAIL t3_pre got %h exp %h", obs, exp);
        else pass_cnt++;
        tick();
        exp = mk(0, 1, 2'b10, 100); total++;
        if (obs !== exp) $display("FAIL t3_tle got %h exp %h", obs, exp);
        else pass_cnt++;
        tick(); tick(); tick();
        total++;
        if (obs !== exp) $display("FAIL t3_held got %h exp %h", obs, exp);
        else pass_cnt++;
        do_start(32'h0040_0014);
        exp = mk(1, 0, 2'b00, 0); total++;
        if (obs !== exp) $display("FAIL t3_restart got %h exp %h", obs, exp);
        else pass_cnt++;
    endtask

    task automatic test_empty_program();
        do_reset();
        do_start(32'h0040_0000);
        exp = mk(0, 1, 2'b11, 0); total++;
        if (obs !== exp) $display("FAIL t4_err got %h exp %h", obs, exp);
        else pass_cnt++;
    endtask

    task automatic test_reset_in_drain();
        do_reset();
        do_start(32'h0040_0014);
        for (int i = 0; i < 7; i++) begin
            mon.pc = 32'h0040_0000 + 32'(4 * i);
            tick();
        end
        #2 rstn = 1'b0;
        #1;
        exp = mk(0, 0, 2'b00, 0); total++;
        if (obs !== exp) $display("FAIL t5_rst got %h exp %h", obs, exp);
        else pass_cnt++;
        @(negedge clk) rstn = 1'b1;
    endtask

    task automatic test_back_to_back();
        do_reset();
        mon.pc = 32'h0040_0000;
        do_start(32'h0040_000c);
        tick();
        mon.pc = 32'h0040_0004;
        tick();
        mon.pc = 32'h0040_0008;
        do_start(32'h0040_0004);
        exp = mk(1, 0, 2'b00, 3); total++;
        if (obs !== exp) $display("FAIL t5_ignore got %h exp %h", obs, exp);
        else pass_cnt++;
        mon.pc = 32'h0040_000c;
        tick();
        for (int i = 0; i < 4; i++) begin
            mon.pc = 32'h0040_0010 + 32'(4 * i);
            tick();
        end
        exp = mk(0, 1, 2'b01, 8); total++;
        if (obs !== exp) $display("FAIL t5_done got %h exp %h", obs, exp);
        else pass_cnt++;
    endtask

    task automatic test_pc_range();
        do_reset();
        mon.pc = 32'h0040_0000;
        do_start(32'h0040_0020);
        tick();
        mon.pc = 32'h0040_0400;
        tick();
`ifdef PC_RANGE_CHECK_EN
        exp = mk(0, 1, 2'b11, 2); total++;
        if (obs !== exp) $display("FAIL t6_err got %h exp %h", obs, exp);
        else pass_cnt++;
`else
        exp = mk(1, 0, 2'b00, 2); total++;
        if (obs !== exp) $display("FAIL t6_run got %h exp %h", obs, exp);
        else pass_cnt++;
        for (int i = 0; i < 98; i++) tick();
        exp = mk(0, 1, 2'b10, 100); total++;
        if (obs !== exp) $display("FAIL t6_tle got %h exp %h", obs, exp);
        else pass_cnt++;
`endif
    endtask

    initial begin
        test_reset();
        test_normal_exit();
        test_stalled_drain();
        test_timeout();
        test_empty_program();
        test_reset_in_drain();
        test_back_to_back();
        test_pc_range();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
